// File: rtl/carry_select_subtractor_pipe_pkg.sv
// Shared constants, types and helpers for the carry-select subtractor pipeline.
//   DEF_WIDTH / DEF_BLOCK : default operand width and borrow-select block size
//   nblk()                : number of borrow-select blocks for a given width/block
//   blk_cand_t            : candidate pair of one upper block (borrow-in 0 and 1)
package carry_select_subtractor_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_BLOCK = 4;

  // Number of borrow-select blocks; WIDTH must divide evenly and give at least 2.
  function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

  // Candidate results of one block: diff0/bo0 assume borrow-in 0, diff1/bo1 borrow-in 1.
  // Field width is tied to DEF_BLOCK, so a pipeline instance must use BLOCK == DEF_BLOCK.
  typedef struct packed {
    logic [DEF_BLOCK-1:0] diff0;
    logic                 bo0;
    logic [DEF_BLOCK-1:0] diff1;
    logic                 bo1;
  } blk_cand_t;

endpackage

// File: rtl/carry_select_subtractor_pipe_if.sv
// Operand/result handshake bundle for the carry-select subtractor pipeline.
//   in_valid/in_ready   : operand beat handshake (a, b, bin)
//   out_valid/out_ready : result beat handshake (diff, bout, ovf)
// master = producer of operands and consumer of results, slave = the pipeline.
interface carry_select_subtractor_pipe_if #(
  parameter int unsigned WIDTH = carry_select_subtractor_pipe_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/carry_select_subtractor_pipe_csel_sub_block.sv
// Combinational BLOCK-bit subtractor producing both candidate results.
//   i_a, i_b : block slices of minuend and subtrahend
//   o_cand   : {diff, borrow} for borrow-in 0 and for borrow-in 1
module csel_sub_block
  import carry_select_subtractor_pipe_pkg::*;
#(
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  output blk_cand_t        o_cand
);

  localparam int unsigned BW1 = BLOCK + 1;

  // Extra top bit goes to 1 exactly when the block result is negative, i.e. a borrow.
  logic [BLOCK:0] w_d0;
  logic [BLOCK:0] w_d1;

  assign w_d0 = {1'b0, i_a} - {1'b0, i_b};
  assign w_d1 = w_d0 - BW1'(1);

  assign o_cand.diff0 = w_d0[BLOCK-1:0];
  assign o_cand.bo0   = w_d0[BLOCK];
  assign o_cand.diff1 = w_d1[BLOCK-1:0];
  assign o_cand.bo1   = w_d1[BLOCK];

endmodule

// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined borrow-select subtractor: diff = a - b - bin (mod 2^WIDTH).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, drops all in-flight beats
//   bus  : slave side of the operand/result handshake bundle
// Stage 1 resolves block 0 and precomputes both candidates of every upper block.
// Stage 2 ripples the selected borrow upward and registers diff/bout/ovf.
module carry_select_subtractor_pipe
  import carry_select_subtractor_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic                          clk,
  input  logic                          rst,
  carry_select_subtractor_pipe_if.slave bus
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned BW1  = BLOCK + 1;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [BLOCK-1:0] r_s1_lo_diff;
  logic             r_s1_lo_bo;
  blk_cand_t        r_s1_cand [NBLK-1:1];
  logic             r_s1_sa;
  logic             r_s1_sb;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_diff;
  logic             r_s2_bout;
  logic             r_s2_ovf;

  logic             w_s2_adv;
  logic             w_in_xfer;
  logic [BLOCK:0]   w_lo;
  blk_cand_t        w_cand [NBLK-1:1];
  logic [WIDTH-1:0] w_sel_diff;
  logic             w_sel_bout;
  logic             w_sel_ovf;

  // Handshake: stage 2 accepts when empty or draining; stage 1 refills behind it.
  assign w_s2_adv     = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s2_adv;
  assign w_in_xfer    = bus.in_valid && bus.in_ready;

  // Block 0 sees the real borrow-in, so it needs only one result.
  assign w_lo = {1'b0, bus.a[BLOCK-1:0]} - {1'b0, bus.b[BLOCK-1:0]} - BW1'(bus.bin);

  for (genvar k = 1; k < NBLK; k++) begin : g_blk
    csel_sub_block #(.BLOCK(BLOCK)) u_blk (
      .i_a    (bus.a[k*BLOCK +: BLOCK]),
      .i_b    (bus.b[k*BLOCK +: BLOCK]),
      .o_cand (w_cand[k])
    );
  end

  // Borrow select ripple: each block's chosen borrow-out picks the next block's candidate.
  always_comb begin
    w_sel_diff              = '0;
    w_sel_bout              = r_s1_lo_bo;
    w_sel_diff[BLOCK-1:0]   = r_s1_lo_diff;
    for (int unsigned k = 1; k < NBLK; k++) begin
      if (w_sel_bout) begin
        w_sel_diff[k*BLOCK +: BLOCK] = r_s1_cand[k].diff1;
        w_sel_bout                   = r_s1_cand[k].bo1;
      end else begin
        w_sel_diff[k*BLOCK +: BLOCK] = r_s1_cand[k].diff0;
        w_sel_bout                   = r_s1_cand[k].bo0;
      end
    end
  end

  assign w_sel_ovf = (r_s1_sa != r_s1_sb) && (w_sel_diff[MSB] != r_s1_sa);

  // Stage 1: load on input transfer, empty when it advances without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_lo_diff <= '0;
      r_s1_lo_bo   <= 1'b0;
      r_s1_sa      <= 1'b0;
      r_s1_sb      <= 1'b0;
      for (int unsigned k = 1; k < NBLK; k++) begin
        r_s1_cand[k] <= '0;
      end
    end else if (w_in_xfer) begin
      r_s1_valid   <= 1'b1;
      r_s1_lo_diff <= w_lo[BLOCK-1:0];
      r_s1_lo_bo   <= w_lo[BLOCK];
      r_s1_sa      <= bus.a[MSB];
      r_s1_sb      <= bus.b[MSB];
      for (int unsigned k = 1; k < NBLK; k++) begin
        r_s1_cand[k] <= w_cand[k];
      end
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: load on advance, empty on output transfer without advance; data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_diff  <= '0;
      r_s2_bout  <= 1'b0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_diff  <= w_sel_diff;
      r_s2_bout  <= w_sel_bout;
      r_s2_ovf   <= w_sel_ovf;
    end else if (bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.diff      = r_s2_diff;
  assign bus.bout      = r_s2_bout;
  assign bus.ovf       = r_s2_ovf;

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Self-checking bench for carry_select_subtractor_pipe (WIDTH=8, BLOCK=4).
module tb_carry_select_subtractor_pipe;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_out;
  exp_t q[$];

  logic       hold_v;
  logic [7:0] hold_d;
  logic       hold_bo;
  logic       hold_ov;

  carry_select_subtractor_pipe_if #(.WIDTH(8)) bus ();

  carry_select_subtractor_pipe #(.WIDTH(8), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: plain integer subtraction, borrow = negative result, signed overflow rule.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int   d;
    d    = int'(a) - int'(b) - int'(bin);
    e.d  = 8'(d);
    e.bo = (d < 0);
    e.ov = (a[7] != b[7]) && (e.d[7] != a[7]);
    return e;
  endfunction

  // Monitor/scoreboard: evaluated mid-low-phase, when everything for the next edge is settled.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_hold_diff", 32'(bus.diff), 32'(hold_d));
        check("stall_hold_flags", 32'({bus.out_valid, bus.bout, bus.ovf}), 32'({1'b1, hold_bo, hold_ov}));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_pending_beat", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_diff", 32'(bus.diff), 32'(e.d));
          check("sb_bout", 32'(bus.bout), 32'(e.bo));
          check("sb_ovf",  32'(bus.ovf),  32'(e.ov));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.bin));
      hold_v  = bus.out_valid && !bus.out_ready;
      hold_d  = bus.diff;
      hold_bo = bus.bout;
      hold_ov = bus.ovf;
    end
  end

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.bin      = 1'($urandom);
  endtask

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
  endtask

  // Single beat with literal expectations, observed two cycles after it is offered.
  task automatic one_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic ebo, input logic eov);
    @(negedge clk);
    drive_beat(a, b, bin);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #2;
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_diff"},  32'(bus.diff), 32'(ed));
    check({name, "_bout"},  32'(bus.bout), 32'(ebo));
    check({name, "_ovf"},   32'(bus.ovf),  32'(eov));
  endtask

  initial begin
    int   base;
    int   idx;
    logic acc;
    logic [7:0] bp_a [3];
    logic [7:0] bp_b [3];

    n_total = 0;
    n_pass  = 0;
    n_out   = 0;
    hold_v  = 1'b0;
    rst     = 1'b1;
    bus.out_ready = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_diff",      32'(bus.diff),      32'd0);
    check("reset_flags",     32'({bus.bout, bus.ovf}), 32'd0);

    // Directed literal vectors
    one_op("basic",      8'h07, 8'h04, 1'b0, 8'h03, 1'b0, 1'b0);
    one_op("underflow",  8'h03, 8'h04, 1'b0, 8'hFF, 1'b1, 1'b0);
    one_op("bin_sub",    8'hB0, 8'h03, 1'b1, 8'hAC, 1'b0, 1'b0);
    one_op("xblock",     8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    one_op("ovf",        8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    one_op("zero_bin",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    one_op("ff_bin",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    one_op("pos_ovf",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Back-to-back streaming
    @(negedge clk);
    base = n_out;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) drive_beat(8'(i * 37 + 5), 8'(i * 91 + 17), 1'(i % 3 == 0));
      else drive_idle();
      #2;
      if (i < 16) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i >= 2) check("stream_out_valid", 32'(bus.out_valid), 32'd1);
    end
    repeat (3) @(negedge clk);
    #2;
    check("stream_count", 32'(n_out - base), 32'd16);

    // Backpressure: 3 beats offered, consumer stalled for the first 5 cycles
    bp_a[0] = 8'h55; bp_b[0] = 8'hAA;
    bp_a[1] = 8'h01; bp_b[1] = 8'h02;
    bp_a[2] = 8'hC8; bp_b[2] = 8'h37;
    base = n_out;
    idx  = 0;
    acc  = 1'b0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      if (acc) idx++;
      if (idx < 3) drive_beat(bp_a[idx], bp_b[idx], 1'(idx == 1));
      else drive_idle();
      bus.out_ready = (cyc >= 5);
      #2;
      acc = bus.in_valid && bus.in_ready;
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid",    32'(bus.out_valid), 32'd1);
      end
    end
    check("bp_count", 32'(n_out - base), 32'd3);
    check("bp_all_accepted", 32'(idx), 32'd3);

    // Reset with both stages full
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_beat(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    drive_beat(8'h9A, 8'hBC, 1'b1);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #2;
    check("pre_rst_full_out_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_full_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_rst_diff",      32'(bus.diff),      32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Pipeline still works after the reset
    one_op("after_rst", 8'h40, 8'h41, 1'b0, 8'hFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
